// File: rtl/pll_reset_pkg.sv
// Shared types and constants for the auxiliary PLL reset sequencer.
package pll_reset_pkg;

   localparam int RETRY_W = 4;

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      REL_TIMER = 3'd3,
      REL_VIDEO = 3'd4,
      RUN       = 3'd5
   } pll_state_e;

   function automatic logic [RETRY_W-1:0] satInc(input logic [RETRY_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the reset sequencer (master) and the PLL / reset consumers (slave).
interface pll_reset_sequencer_if;
   import pll_reset_pkg::*;

   logic               pll_locked_i;
   logic               force_relock_i;
   logic               pll_rst_o;
   logic               timer_rstn_o;
   logic               video_rstn_o;
   logic               gpu_rstn_o;
   logic               all_ready_o;
   logic               lock_lost_o;
   logic [RETRY_W-1:0] retry_count_o;

   modport master (
      input  pll_locked_i, force_relock_i,
      output pll_rst_o, timer_rstn_o, video_rstn_o, gpu_rstn_o,
             all_ready_o, lock_lost_o, retry_count_o
   );

   modport slave (
      output pll_locked_i, force_relock_i,
      input  pll_rst_o, timer_rstn_o, video_rstn_o, gpu_rstn_o,
             all_ready_o, lock_lost_o, retry_count_o
   );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser, async active-low reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic rstN,
   input  logic d,
   output logic q
);

   logic metaQ;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         metaQ <= 1'b0;
         q     <= 1'b0;
      end else begin
         metaQ <= d;
         q     <= metaQ;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, qualifies a stable lock, then releases timer, video and GPU resets in order.
//  state     | meaning
//  RESET_PLL | PLL RST held high for PLL_RST_CYCLES
//  WAIT_LOCK | waiting for synchronised lock, bounded by LOCK_TIMEOUT_CYCLES
//  STABLE    | lock high, counting towards LOCK_STABLE_CYCLES
//  REL_TIMER | timer domain released
//  REL_VIDEO | timer and video domains released
//  RUN       | all domains released
module pll_reset_sequencer
   import pll_reset_pkg::*;
#(
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_STABLE_CYCLES  = 4096,
   parameter int LOCK_TIMEOUT_CYCLES = 1048576,
   parameter int STAGGER_CYCLES      = 256,
   parameter int CNT_W               = 21
) (
   input logic                   clkin,
   input logic                   rstn,
   pll_reset_sequencer_if.master bus
);

   logic               lockS;
   logic               released;
   logic               lockLost;
   pll_state_e         stateQ, stateD;
   logic [CNT_W-1:0]   cntQ, cntD;
   logic [RETRY_W-1:0] retryQ, retryD;

   sync_2ff uLockSync (
      .clk  (clkin),
      .rstN (rstn),
      .d    (bus.pll_locked_i),
      .q    (lockS)
   );

   assign released = stateQ inside {REL_TIMER, REL_VIDEO, RUN};
   assign lockLost = released && !lockS;

   always_comb begin
      stateD = stateQ;
      cntD   = cntQ + 1'b1;
      retryD = retryQ;
      case (stateQ)
         RESET_PLL: if (cntQ == CNT_W'(PLL_RST_CYCLES - 1)) begin
            stateD = WAIT_LOCK;
            cntD   = '0;
         end
         WAIT_LOCK: if (lockS) begin
            stateD = STABLE;
            cntD   = '0;
         end else if (cntQ == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
            stateD = RESET_PLL;
            cntD   = '0;
            retryD = satInc(retryQ);
         end
         // a single low sample restarts qualification with a fresh timeout
         STABLE: if (!lockS) begin
            stateD = WAIT_LOCK;
            cntD   = '0;
         end else if (cntQ == CNT_W'(LOCK_STABLE_CYCLES)) begin
            stateD = REL_TIMER;
            cntD   = '0;
         end
         REL_TIMER: if (cntQ == CNT_W'(STAGGER_CYCLES - 1)) begin
            stateD = REL_VIDEO;
            cntD   = '0;
         end
         REL_VIDEO: if (cntQ == CNT_W'(STAGGER_CYCLES - 1)) begin
            stateD = RUN;
            cntD   = '0;
         end
         RUN:     cntD = cntQ;
         default: begin
            stateD = RESET_PLL;
            cntD   = '0;
         end
      endcase
      // relock requests are not timeouts, so they never bump the retry count
      if (lockLost || (bus.force_relock_i && stateQ != RESET_PLL)) begin
         stateD = RESET_PLL;
         cntD   = '0;
         retryD = retryQ;
      end
   end

   always_ff @(posedge clkin or negedge rstn) begin
      if (!rstn) begin
         stateQ           <= RESET_PLL;
         cntQ             <= '0;
         retryQ           <= '0;
         bus.pll_rst_o    <= 1'b1;
         bus.timer_rstn_o <= 1'b0;
         bus.video_rstn_o <= 1'b0;
         bus.gpu_rstn_o   <= 1'b0;
         bus.all_ready_o  <= 1'b0;
         bus.lock_lost_o  <= 1'b0;
      end else begin
         stateQ           <= stateD;
         cntQ             <= cntD;
         retryQ           <= retryD;
         bus.pll_rst_o    <= (stateD == RESET_PLL);
         bus.timer_rstn_o <= stateD inside {REL_TIMER, REL_VIDEO, RUN};
         bus.video_rstn_o <= stateD inside {REL_VIDEO, RUN};
         bus.gpu_rstn_o   <= (stateD == RUN);
         bus.all_ready_o  <= (stateD == RUN);
         bus.lock_lost_o  <= lockLost;
      end
   end

   assign bus.retry_count_o = retryQ;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: deadline-based reference model feeds a per-cycle expectation queue.
module tb_pll_reset_sequencer;

   localparam int P_RST = 4;
   localparam int P_STB = 8;
   localparam int P_STG = 4;
   localparam int P_TO  = 64;

   typedef struct packed {
      logic       pllRst;
      logic       timer;
      logic       video;
      logic       gpu;
      logic       ready;
      logic       lost;
      logic [3:0] retry;
   } obs_t;

   localparam obs_t RESET_OBS = obs_t'(10'b10_0000_0000);

   typedef enum {M_RST, M_WAIT, M_QUAL, M_REL} mph_t;

   logic clkin = 1'b0;
   logic rstn  = 1'b1;
   int   total = 0;
   int   bad   = 0;

   pll_reset_sequencer_if bus ();

   pll_reset_sequencer #(
      .PLL_RST_CYCLES      (P_RST),
      .LOCK_STABLE_CYCLES  (P_STB),
      .LOCK_TIMEOUT_CYCLES (P_TO),
      .STAGGER_CYCLES      (P_STG),
      .CNT_W               (21)
   ) dut (
      .clkin (clkin),
      .rstn  (rstn),
      .bus   (bus)
   );

   always #20 clkin = ~clkin;

   obs_t expQ[$];

   function automatic obs_t sample();
      obs_t o;
      o.pllRst = bus.pll_rst_o;
      o.timer  = bus.timer_rstn_o;
      o.video  = bus.video_rstn_o;
      o.gpu    = bus.gpu_rstn_o;
      o.ready  = bus.all_ready_o;
      o.lost   = bus.lock_lost_o;
      o.retry  = bus.retry_count_o;
      return o;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clkin);
      #1;
   endtask

   // Reference model: each phase ends at an absolute cycle deadline.
   initial begin : model
      mph_t mPh;
      int   mCyc, mDl, mLvl, mRetry;
      bit   [1:0] mPipe;
      bit   lk, fr, lost;
      obs_t e;
      mPh = M_RST; mCyc = 0; mDl = P_RST; mLvl = 0; mRetry = 0; mPipe = 2'b00;
      forever begin
         @(posedge clkin or negedge rstn);
         if (!rstn) begin
            mPh = M_RST; mCyc = 0; mDl = P_RST; mLvl = 0; mRetry = 0; mPipe = 2'b00;
            expQ.delete();
         end else begin
            lk    = mPipe[1];
            fr    = bus.force_relock_i;
            lost  = 1'b0;
            mPipe = {mPipe[0], bus.pll_locked_i};
            mCyc++;
            case (mPh)
               M_RST: if (mCyc == mDl) begin mPh = M_WAIT; mDl = mCyc + P_TO; end
               M_WAIT: begin
                  if (fr) begin mPh = M_RST; mDl = mCyc + P_RST; end
                  else if (lk) begin mPh = M_QUAL; mDl = mCyc + P_STB + 1; end
                  else if (mCyc == mDl) begin
                     mPh = M_RST; mDl = mCyc + P_RST;
                     if (mRetry < 15) mRetry++;
                  end
               end
               M_QUAL: begin
                  if (fr) begin mPh = M_RST; mDl = mCyc + P_RST; end
                  else if (!lk) begin mPh = M_WAIT; mDl = mCyc + P_TO; end
                  else if (mCyc == mDl) begin mPh = M_REL; mLvl = 1; mDl = mCyc + P_STG; end
               end
               M_REL: begin
                  if (fr || !lk) begin
                     lost = !lk; mPh = M_RST; mLvl = 0; mDl = mCyc + P_RST;
                  end else if (mLvl < 3 && mCyc == mDl) begin
                     mLvl++; mDl = mCyc + P_STG;
                  end
               end
               default: ;
            endcase
            e.pllRst = (mPh == M_RST);
            e.timer  = (mLvl >= 1);
            e.video  = (mLvl >= 2);
            e.gpu    = (mLvl >= 3);
            e.ready  = (mLvl == 3);
            e.lost   = lost;
            e.retry  = 4'(mRetry);
            expQ.push_back(e);
         end
      end
   end

   initial begin : monitor
      obs_t g, e;
      forever begin
         @(negedge clkin);
         g = sample();
         if (!rstn || expQ.size() == 0) e = RESET_OBS;
         else e = expQ.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL cycle_outputs t=%0t got=%b expected=%b", $time, g, e);
         end
         total++;
         if ((g.video && !g.timer) || (g.gpu && !g.video) || (g.ready !== g.gpu)) begin
            bad++;
            $display("FAIL release_order t=%0t got=%b required timer>=video>=gpu, ready==gpu", $time, g);
         end
      end
   end

   task automatic measureRelease(input int bound, output int tT, output int tV, output int tG);
      tT = -1; tV = -1; tG = -1;
      for (int i = 0; i < bound; i++) begin
         cyc(1);
         if (tT < 0 && bus.timer_rstn_o) tT = i;
         if (tV < 0 && bus.video_rstn_o) tV = i;
         if (tG < 0 && bus.gpu_rstn_o)   tG = i;
      end
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int tT, tV, tG, n, lostCnt, rstCnt, found;
      bus.pll_locked_i   = 1'b0;
      bus.force_relock_i = 1'b0;
      #1 rstn = 1'b0;
      cyc(3);
      #2 rstn = 1'b1;

      // power-up: PLL reset length, then lock raised after cycle 10
      n = -1;
      for (int i = 1; i <= 20 && n < 0; i++) begin
         cyc(1);
         if (!bus.pll_rst_o) n = i;
      end
      check("pll_rst_len", n, P_RST);
      cyc(10 - n);
      bus.pll_locked_i = 1'b1;
      measureRelease(40, tT, tV, tG);
      check("timer_rise", tT, P_STB + 3);
      check("video_rise", tV, P_STB + 3 + P_STG);
      check("gpu_rise", tG, P_STB + 3 + 2 * P_STG);

      // lock dropped in RUN
      bus.pll_locked_i = 1'b0;
      n = -1; lostCnt = 0; rstCnt = 0;
      for (int i = 1; i <= 12; i++) begin
         cyc(1);
         if (n < 0 && !bus.all_ready_o) n = i;
         lostCnt += int'(bus.lock_lost_o);
         rstCnt  += int'(bus.pll_rst_o);
      end
      check("lock_loss_latency", n, 3);
      check("lock_lost_pulses", lostCnt, 1);
      check("loss_pll_rst_len", rstCnt, P_RST);
      check("loss_retry", int'(bus.retry_count_o), 0);
      bus.pll_locked_i = 1'b1;
      measureRelease(40, tT, tV, tG);
      check("relock_timer_rise", tT, P_STB + 3);
      check("relock_gpu_rise", tG, P_STB + 3 + 2 * P_STG);

      // forced relock in RUN, second request inside the reset window
      rstCnt = 0; lostCnt = 0;
      for (int i = 1; i <= 12; i++) begin
         bus.force_relock_i = (i == 1 || i == 3);
         cyc(1);
         rstCnt  += int'(bus.pll_rst_o);
         lostCnt += int'(bus.lock_lost_o);
      end
      bus.force_relock_i = 1'b0;
      check("force_pll_rst_len", rstCnt, P_RST);
      check("force_no_lost", lostCnt, 0);
      check("force_retry", int'(bus.retry_count_o), 0);

      // one-cycle glitch during STABLE
      bus.pll_locked_i = 1'b0;
      cyc(20);
      bus.pll_locked_i = 1'b1;
      cyc(5);
      bus.pll_locked_i = 1'b0;
      cyc(1);
      bus.pll_locked_i = 1'b1;
      measureRelease(40, tT, tV, tG);
      check("glitch_timer_rise", tT, P_STB + 3);
      check("glitch_video_rise", tV, P_STB + 3 + P_STG);

      // async reset in REL_VIDEO
      bus.force_relock_i = 1'b1;
      cyc(1);
      bus.force_relock_i = 1'b0;
      found = 0;
      for (int i = 0; i < 100 && found == 0; i++) begin
         cyc(1);
         if (bus.video_rstn_o && !bus.gpu_rstn_o) found = 1;
      end
      check("reach_rel_video", found, 1);
      #5 rstn = 1'b0;
      #1 check("async_reset_outputs", int'(sample()), int'(RESET_OBS));
      bus.pll_locked_i = 1'b0;
      cyc(3);
      #2 rstn = 1'b1;

      // lock never arrives: retry count climbs and saturates
      for (int k = 1; k <= 17; k++) begin
         cyc(P_RST + P_TO);
         check($sformatf("retry_after_%0d", k), int'(bus.retry_count_o), (k < 15) ? k : 15);
      end

      // random lock behaviour and relock requests
      for (int i = 0; i < 2000; i++) begin
         if (bus.pll_locked_i) begin
            if ($urandom_range(0, 199) == 0) bus.pll_locked_i = 1'b0;
         end else if ($urandom_range(0, 19) == 0) begin
            bus.pll_locked_i = 1'b1;
         end
         bus.force_relock_i = ($urandom_range(0, 299) == 0);
         cyc(1);
      end
      bus.force_relock_i = 1'b0;
      cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
